sample_ctrl: RTL and testbench
==============================

SAMPLE_CTRL -- requirements
Module: sample_ctrl

Interface
REQ-001 SHALL have parameters: IA_W, default 12, source-buffer address width; WA_W, default 10, weight-buffer address width.
REQ-002 SHALL have ports: clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: s_init  in  1  one-cycle pulse from batch control that starts one sample.
REQ-005 SHALL have ports: out_busy  in  1  output control is still draining core sums.
REQ-006 SHALL have ports: s_fin  out  1  one-cycle pulse when the sample is complete.
REQ-007 SHALL have ports: k_init  out  1  one-cycle pulse that clears core accumulators.
REQ-008 SHALL have ports: exec  out  1  core MAC enable.
REQ-009 SHALL have ports: k_fin  out  1  one-cycle pulse that closes one output position.
REQ-010 SHALL have ports: ia  out  IA_W  source-buffer read address.
REQ-011 SHALL have ports: wa  out  WA_W  weight read address.
REQ-012 SHALL have ports: id 4, is 10, ih 5, iw 5, oh 5, ow 5, ks 10, kh 5, kw 5  in  geometry (channels, channel stride, input/output/kernel sizes), held stable while busy.

Function
REQ-013 SHALL implement states IDLE, INIT, EXEC, FIN, WAIT, DONE.
REQ-014 SHALL go IDLE->INIT on s_init, clearing oy, ox, c, y, x.
REQ-015 INIT SHALL assert k_init for one cycle only when out_busy=0; otherwise SHALL hold with k_init=0.
REQ-016 SHALL go INIT->EXEC next cycle; EXEC SHALL assert exec for exactly id*kh*kw consecutive cycles.
REQ-017 During exec: ia SHALL = ox + oy*iw + c*is + y*iw + x and wa SHALL = c*ks + y*kw + x (mod 2^width), x innermost, then y, then c.
REQ-018 Addresses SHALL be formed with incremental adders (row/channel base registers), not multipliers.
REQ-019 In the k_init cycle, ia and wa SHALL already present the first exec address.
REQ-020 After the last exec, SHALL enter FIN and assert k_fin for one cycle.
REQ-021 From FIN, SHALL advance ox (wrap at ow, then oy++) and go to INIT if positions remain; else go to WAIT.
REQ-022 WAIT SHALL hold until out_busy=0, then go to DONE.
REQ-023 DONE SHALL pulse s_fin for one cycle, then return to IDLE.
REQ-024 s_init outside IDLE SHALL abort the sample and restart at INIT (oy=ox=0); no k_fin or s_fin SHALL be issued for the aborted work.
REQ-025 Outside EXEC, exec SHALL be 0; outside INIT and EXEC, ia and wa SHALL hold their last value.
REQ-026 Zero in any of id, kh, kw, oh, ow SHALL produce no exec; SHALL emit s_fin two cycles after s_init.
REQ-027 Outputs SHALL be registered; k_init, k_fin and s_fin SHALL never be high in the same cycle.

Reset
REQ-028 reset SHALL force IDLE asynchronously.
REQ-029 reset SHALL clear all counters and set s_fin, k_init, exec, k_fin, ia and wa to 0.
REQ-030 Reset mid-sample SHALL discard progress; the first cycle after release SHALL be IDLE with no pulses.

Structure
REQ-031 The state enum and geometry field widths SHALL live in a shared package, tiny_dnn_pkg.
REQ-032 One sub-module, sample_addr_gen, SHALL hold the c/y/x counters and ia/wa incremental adders, exposing a last flag.
REQ-033 The FSM SHALL stay in sample_ctrl.

Verification
REQ-034 id=1, ih=iw=3, kh=kw=2, oh=ow=2, out_busy=0 -> 4 k_init, 16 exec, 4 k_fin, 1 s_fin; position (0,0) ia 0,1,3,4, wa 0,1,2,3; position (0,1) ia 1,2,4,5; position (1,0) ia 3,4,6,7.
REQ-035 As REQ-034 with id=2, is=9, ks=4 -> 8 exec per position; second-channel ia 9,10,12,13, wa 4,5,6,7.
REQ-036 out_busy held high 5 cycles after the first k_fin -> second k_init delayed until out_busy falls; s_fin delayed likewise at the end.
REQ-037 s_init re-pulsed mid-EXEC -> k_init again with ia=0, wa=0; exactly 4 k_fin follow the restart.
REQ-038 reset asserted mid-EXEC -> all outputs 0 in the same cycle; next s_init runs a full clean sample.
REQ-039 kw=0 -> no exec, no k_init, s_fin two cycles after s_init.

Source files
------------

// File: rtl/tiny_dnn_pkg.sv
// Shared types for the tiny DNN sample path: sequencer states and geometry field widths.
package tiny_dnn_pkg;

  localparam int unsigned ChanW   = 4;   // id
  localparam int unsigned StrideW = 10;  // is, ks
  localparam int unsigned DimW    = 5;   // ih, iw, oh, ow, kh, kw

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StExec,
    StFin,
    StWait,
    StDone
  } sample_state_e;

endpackage

// File: rtl/sample_ctrl_if.sv
// Handshake and address bundle between batch control, sample_ctrl and the MAC core.
interface sample_ctrl_if #(
  parameter int unsigned IA_W = 12,
  parameter int unsigned WA_W = 10
) ();

  logic            s_init;
  logic            out_busy;
  logic            s_fin;
  logic            k_init;
  logic            exec;
  logic            k_fin;
  logic [IA_W-1:0] ia;
  logic [WA_W-1:0] wa;

  modport master (
    output s_init,
    output out_busy,
    input  s_fin,
    input  k_init,
    input  exec,
    input  k_fin,
    input  ia,
    input  wa
  );

  modport slave (
    input  s_init,
    input  out_busy,
    output s_fin,
    output k_init,
    output exec,
    output k_fin,
    output ia,
    output wa
  );

endinterface

// File: rtl/sample_addr_gen.sv
// Walks x (innermost), y, c over one kernel window and forms source/weight addresses
// with running base registers instead of multipliers.
module sample_addr_gen
  import tiny_dnn_pkg::*;
#(
  parameter int unsigned IA_W = 12,
  parameter int unsigned WA_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [IA_W-1:0]    pos_base,
  input  logic [ChanW-1:0]   id,
  input  logic [StrideW-1:0] is,
  input  logic [DimW-1:0]    iw,
  input  logic [StrideW-1:0] ks,
  input  logic [DimW-1:0]    kh,
  input  logic [DimW-1:0]    kw,
  output logic [IA_W-1:0]    ia,
  output logic [WA_W-1:0]    wa,
  output logic               last
);

  logic [DimW-1:0]  x_q, x_d, y_q, y_d;
  logic [ChanW-1:0] c_q, c_d;
  logic [IA_W-1:0]  ia_q, ia_d, ia_row_q, ia_row_d, ia_ch_q, ia_ch_d;
  logic [WA_W-1:0]  wa_q, wa_d, wa_row_q, wa_row_d, wa_ch_q, wa_ch_d;
  logic             x_end, y_end, c_end;

  assign x_end = (x_q == kw - DimW'(1));
  assign y_end = (y_q == kh - DimW'(1));
  assign c_end = (c_q == id - ChanW'(1));
  assign last  = x_end & y_end & c_end;

  assign ia = ia_q;
  assign wa = wa_q;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    c_d      = c_q;
    ia_d     = ia_q;
    ia_row_d = ia_row_q;
    ia_ch_d  = ia_ch_q;
    wa_d     = wa_q;
    wa_row_d = wa_row_q;
    wa_ch_d  = wa_ch_q;
    if (load) begin
      x_d      = '0;
      y_d      = '0;
      c_d      = '0;
      ia_d     = pos_base;
      ia_row_d = pos_base;
      ia_ch_d  = pos_base;
      wa_d     = '0;
      wa_row_d = '0;
      wa_ch_d  = '0;
    end else if (step) begin
      if (!x_end) begin
        x_d  = x_q + DimW'(1);
        ia_d = ia_q + IA_W'(1);
        wa_d = wa_q + WA_W'(1);
      end else if (!y_end) begin
        x_d      = '0;
        y_d      = y_q + DimW'(1);
        ia_row_d = ia_row_q + IA_W'(iw);
        ia_d     = ia_row_d;
        wa_row_d = wa_row_q + WA_W'(kw);
        wa_d     = wa_row_d;
      end else if (!c_end) begin
        x_d      = '0;
        y_d      = '0;
        c_d      = c_q + ChanW'(1);
        ia_ch_d  = ia_ch_q + IA_W'(is);
        ia_row_d = ia_ch_d;
        ia_d     = ia_ch_d;
        wa_ch_d  = wa_ch_q + WA_W'(ks);
        wa_row_d = wa_ch_d;
        wa_d     = wa_ch_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      ia_q     <= '0;
      ia_row_q <= '0;
      ia_ch_q  <= '0;
      wa_q     <= '0;
      wa_row_q <= '0;
      wa_ch_q  <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      ia_q     <= ia_d;
      ia_row_q <= ia_row_d;
      ia_ch_q  <= ia_ch_d;
      wa_q     <= wa_d;
      wa_row_q <= wa_row_d;
      wa_ch_q  <= wa_ch_d;
    end
  end

endmodule

// File: rtl/sample_ctrl.sv
// Per-sample sequencer: steps over output positions and runs one kernel window per position
// through the MAC core. All outputs come straight from flops.
module sample_ctrl
  import tiny_dnn_pkg::*;
#(
  parameter int unsigned IA_W = 12,
  parameter int unsigned WA_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ChanW-1:0]   id,
  input  logic [StrideW-1:0] is,
  input  logic [DimW-1:0]    ih,
  input  logic [DimW-1:0]    iw,
  input  logic [DimW-1:0]    oh,
  input  logic [DimW-1:0]    ow,
  input  logic [StrideW-1:0] ks,
  input  logic [DimW-1:0]    kh,
  input  logic [DimW-1:0]    kw,
  sample_ctrl_if.slave       bus
);

  sample_state_e   state_q, state_d;
  logic            k_init_q, k_init_d, exec_q, exec_d, k_fin_q, k_fin_d, s_fin_q, s_fin_d;
  logic [DimW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [IA_W-1:0] row_base_q, row_base_d, pos_base_q, pos_base_d;
  logic            geom_nz, ox_end, pos_last, clear_pos, adv_pos, last;
  logic [IA_W-1:0] ia;
  logic [WA_W-1:0] wa;
  logic            unused_ih;

  // Input height only bounds the source buffer; addressing never needs it.
  assign unused_ih = ^ih;

  assign geom_nz  = (id != '0) && (kh != '0) && (kw != '0) && (oh != '0) && (ow != '0);
  assign ox_end   = (ox_q == ow - DimW'(1));
  assign pos_last = ox_end && (oy_q == oh - DimW'(1));

  always_comb begin
    state_d   = state_q;
    clear_pos = 1'b0;
    adv_pos   = 1'b0;
    if (bus.s_init) begin
      // A new s_init always restarts from the first position, abandoning any work in flight.
      state_d   = StInit;
      clear_pos = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StInit: begin
          if (!geom_nz)      state_d = bus.out_busy ? StWait : StDone;
          else if (k_init_q) state_d = StExec;
        end
        StExec: if (last) state_d = StFin;
        StFin: begin
          if (pos_last) begin
            state_d = StWait;
          end else begin
            state_d = StInit;
            adv_pos = 1'b1;
          end
        end
        StWait: if (!bus.out_busy) state_d = StDone;
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    // k_init only fires once output control has drained the previous sums.
    k_init_d = (state_d == StInit) && !bus.out_busy && geom_nz;
    exec_d   = (state_d == StExec);
    k_fin_d  = (state_d == StFin);
    s_fin_d  = (state_d == StDone);
  end

  always_comb begin
    ox_d       = ox_q;
    oy_d       = oy_q;
    row_base_d = row_base_q;
    pos_base_d = pos_base_q;
    if (clear_pos) begin
      ox_d       = '0;
      oy_d       = '0;
      row_base_d = '0;
      pos_base_d = '0;
    end else if (adv_pos) begin
      if (ox_end) begin
        ox_d       = '0;
        oy_d       = oy_q + DimW'(1);
        row_base_d = row_base_q + IA_W'(iw);
        pos_base_d = row_base_d;
      end else begin
        ox_d       = ox_q + DimW'(1);
        pos_base_d = pos_base_q + IA_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      k_init_q   <= 1'b0;
      exec_q     <= 1'b0;
      k_fin_q    <= 1'b0;
      s_fin_q    <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      row_base_q <= '0;
      pos_base_q <= '0;
    end else begin
      state_q    <= state_d;
      k_init_q   <= k_init_d;
      exec_q     <= exec_d;
      k_fin_q    <= k_fin_d;
      s_fin_q    <= s_fin_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      row_base_q <= row_base_d;
      pos_base_q <= pos_base_d;
    end
  end

  // Reloading on every INIT entry makes the first address visible in the k_init cycle.
  sample_addr_gen #(
    .IA_W(IA_W),
    .WA_W(WA_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (state_d == StInit),
    .step     (state_q == StExec),
    .pos_base (pos_base_d),
    .id       (id),
    .is       (is),
    .iw       (iw),
    .ks       (ks),
    .kh       (kh),
    .kw       (kw),
    .ia       (ia),
    .wa       (wa),
    .last     (last)
  );

  assign bus.k_init = k_init_q;
  assign bus.exec   = exec_q;
  assign bus.k_fin  = k_fin_q;
  assign bus.s_fin  = s_fin_q;
  assign bus.ia     = ia;
  assign bus.wa     = wa;

endmodule

// File: tb/tb_sample_ctrl.sv
// Directed bench for sample_ctrl: a table of geometries/scenarios plus a reset-mid-exec sequence.
module tb_sample_ctrl;

  localparam int unsigned IaW = 12;
  localparam int unsigned WaW = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id;
  logic [9:0] is, ks;
  logic [4:0] ih, iw, oh, ow, kh, kw;

  sample_ctrl_if #(.IA_W(IaW), .WA_W(WaW)) bus ();

  sample_ctrl #(.IA_W(IaW), .WA_W(WaW)) dut (
    .clk   (clk),
    .reset (reset),
    .id    (id),
    .is    (is),
    .ih    (ih),
    .iw    (iw),
    .oh    (oh),
    .ow    (ow),
    .ks    (ks),
    .kh    (kh),
    .kw    (kw),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id, is, iw, oh, ow, kh, kw, ks;
    int busy_hold;  // cycles out_busy is held high after each k_fin (0 = never)
    int abort_at;   // re-pulse s_init after this many exec cycles (0 = never)
    int exp_ki, exp_ex, exp_kf, exp_sf;  // expected counts and s_fin cycle after s_init
  } vec_t;

  vec_t tbl[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int a_id, a_is, a_iw, a_oh, a_ow, a_kh, a_kw, a_ks,
                              input int a_busy, a_abort, a_ki, a_ex, a_kf, a_sf);
    vec_t v;
    v.id = a_id; v.is = a_is; v.iw = a_iw; v.oh = a_oh; v.ow = a_ow;
    v.kh = a_kh; v.kw = a_kw; v.ks = a_ks; v.busy_hold = a_busy; v.abort_at = a_abort;
    v.exp_ki = a_ki; v.exp_ex = a_ex; v.exp_kf = a_kf; v.exp_sf = a_sf;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference addresses straight from the closed-form expressions.
  function automatic int model_ia(input vec_t v, input int p, input int k);
    int ox, oy, c, y, x;
    ox = p % v.ow;
    oy = p / v.ow;
    c  = k / (v.kh * v.kw);
    y  = (k / v.kw) % v.kh;
    x  = k % v.kw;
    return (ox + oy * v.iw + c * v.is + y * v.iw + x) % (1 << IaW);
  endfunction

  function automatic int model_wa(input vec_t v, input int k);
    int c, y, x;
    c = k / (v.kh * v.kw);
    y = (k / v.kw) % v.kh;
    x = k % v.kw;
    return (c * v.ks + y * v.kw + x) % (1 << WaW);
  endfunction

  task automatic set_geom(input vec_t v);
    id = 4'(v.id); is = 10'(v.is); ks = 10'(v.ks);
    iw = 5'(v.iw); ih = 5'(v.iw); oh = 5'(v.oh); ow = 5'(v.ow); kh = 5'(v.kh); kw = 5'(v.kw);
  endtask

  task automatic run_sample(input int idx, input vec_t v);
    int   n_ki, n_ex, n_kf, n_sf, cyc, sf_cyc, busy_left, n_per;
    logic prev_busy, aborted, ki, ex, kf, sf;
    logic [31:0] last_ia, last_wa;
    n_ki = 0; n_ex = 0; n_kf = 0; n_sf = 0; cyc = 0; sf_cyc = -1; busy_left = 0;
    aborted = 1'b0; last_ia = 0; last_wa = 0;
    n_per = v.id * v.kh * v.kw;
    set_geom(v);
    @(negedge clk);
    bus.s_init   = 1'b1;
    bus.out_busy = 1'b0;
    prev_busy    = 1'b0;
    while (n_sf == 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      bus.s_init = 1'b0;
      ki = bus.k_init; ex = bus.exec; kf = bus.k_fin; sf = bus.s_fin;
      check($sformatf("v%0d pulse overlap c%0d", idx, cyc),
            32'(int'(ki) + int'(kf) + int'(sf) <= 1), 32'd1);
      if (ki) begin
        n_ki++;
        check($sformatf("v%0d k_init with out_busy low", idx), 32'(prev_busy), 32'd0);
        if (n_per > 0) begin
          check($sformatf("v%0d k_init ia p%0d", idx, n_ki - 1), 32'(bus.ia),
                32'(model_ia(v, n_ki - 1, 0)));
          check($sformatf("v%0d k_init wa p%0d", idx, n_ki - 1), 32'(bus.wa), 32'd0);
        end
      end
      if (ex) begin
        if (n_per > 0) begin
          check($sformatf("v%0d exec ia #%0d", idx, n_ex), 32'(bus.ia),
                32'(model_ia(v, n_ex / n_per, n_ex % n_per)));
          check($sformatf("v%0d exec wa #%0d", idx, n_ex), 32'(bus.wa),
                32'(model_wa(v, n_ex % n_per)));
        end
        last_ia = 32'(bus.ia);
        last_wa = 32'(bus.wa);
        n_ex++;
      end
      if (kf) begin
        n_kf++;
        check($sformatf("v%0d ia held at k_fin", idx), 32'(bus.ia), last_ia);
        check($sformatf("v%0d wa held at k_fin", idx), 32'(bus.wa), last_wa);
      end
      if (sf) begin
        n_sf++;
        sf_cyc = cyc;
      end
      if (ex && !aborted && v.abort_at > 0 && n_ex == v.abort_at) begin
        bus.s_init = 1'b1;
        aborted    = 1'b1;
        n_ki = 0; n_ex = 0; n_kf = 0; cyc = 0;
      end
      if (kf && v.busy_hold > 0) busy_left = v.busy_hold;
      bus.out_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      prev_busy = bus.out_busy;
    end
    check($sformatf("v%0d k_init count", idx), 32'(n_ki), 32'(v.exp_ki));
    check($sformatf("v%0d exec count", idx), 32'(n_ex), 32'(v.exp_ex));
    check($sformatf("v%0d k_fin count", idx), 32'(n_kf), 32'(v.exp_kf));
    check($sformatf("v%0d s_fin count", idx), 32'(n_sf), 32'd1);
    check($sformatf("v%0d s_fin cycle", idx), 32'(sf_cyc), 32'(v.exp_sf));
    @(negedge clk);
    bus.out_busy = 1'b0;
    check($sformatf("v%0d s_fin single cycle", idx), 32'(bus.s_fin), 32'd0);
    check($sformatf("v%0d idle after s_fin", idx), 32'(bus.exec), 32'd0);
  endtask

  initial begin
    //                id is iw oh ow kh kw ks busy abort  ki  ex kf  sf
    tbl[0] = mk(1, 9, 3, 2, 2, 2, 2, 4, 0, 0, 4, 16, 4, 26);
    tbl[1] = mk(2, 9, 3, 2, 2, 2, 2, 4, 0, 0, 4, 32, 4, 42);
    tbl[2] = mk(1, 9, 3, 2, 2, 2, 2, 4, 5, 0, 4, 16, 4, 45);
    tbl[3] = mk(1, 9, 3, 2, 2, 2, 2, 4, 0, 6, 4, 16, 4, 26);
    tbl[4] = mk(1, 9, 3, 2, 2, 2, 0, 4, 0, 0, 0, 0, 0, 2);
    tbl[5] = mk(1, 9, 3, 0, 2, 2, 2, 4, 0, 0, 0, 0, 0, 2);
    tbl[6] = mk(1, 25, 5, 1, 3, 3, 1, 3, 0, 0, 3, 9, 3, 17);

    reset = 1'b1;
    bus.s_init = 1'b0;
    bus.out_busy = 1'b0;
    set_geom(tbl[0]);
    @(negedge clk);
    check("reset k_init", 32'(bus.k_init), 32'd0);
    check("reset exec", 32'(bus.exec), 32'd0);
    check("reset k_fin", 32'(bus.k_fin), 32'd0);
    check("reset s_fin", 32'(bus.s_fin), 32'd0);
    check("reset ia", 32'(bus.ia), 32'd0);
    check("reset wa", 32'(bus.wa), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle after reset k_init", 32'(bus.k_init), 32'd0);

    for (int i = 0; i < 7; i++) run_sample(i, tbl[i]);

    // Reset in the middle of EXEC, then a clean sample.
    set_geom(tbl[0]);
    @(negedge clk);
    bus.s_init = 1'b1;
    @(negedge clk);
    bus.s_init = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec before reset", 32'(bus.exec), 32'd1);
    check("ia before reset", 32'(bus.ia), 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset exec", 32'(bus.exec), 32'd0);
    check("mid reset k_init", 32'(bus.k_init), 32'd0);
    check("mid reset k_fin", 32'(bus.k_fin), 32'd0);
    check("mid reset s_fin", 32'(bus.s_fin), 32'd0);
    check("mid reset ia", 32'(bus.ia), 32'd0);
    check("mid reset wa", 32'(bus.wa), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post reset idle pulses c%0d", i),
            32'(int'(bus.k_init) + int'(bus.exec) + int'(bus.k_fin) + int'(bus.s_fin)), 32'd0);
    end
    run_sample(7, tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
